systolic_array_ctrl: RTL and testbench
======================================

Name: systolic_array_ctrl

Overview:
Tile sequencer for the 1xN systolic MAC array. On a start command it drives the array's control inputs and the read ports of the weight and activation buffers:
- one accumulator clear,
- then cfg_k_tiles passes of weight load followed by activation compute,
- then a drain.
It sits between the layer-level scheduler (start/done handshake, configuration) and the array plus its SRAM buffers. SRAM read data goes directly to the array; this block only issues addresses and aligned control.

Parameters:
- BN_NUM, 10, outputs per pass (array N)
- ACCU_NUM, 5, array depth (K per pass)
- ADDR_W, 12, buffer address width
- KT_W, 8, width of the tile-count field

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- start  in  1  command pulse; sampled only in IDLE
- cfg_k_tiles  in  KT_W  number of accumulation passes
- cfg_shift  in  8  result right-shift amount
- cfg_wet_base  in  ADDR_W  weight buffer base address
- cfg_act_base  in  ADDR_W  activation buffer base address
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- wet_rd_en  out  1  weight buffer read strobe
- wet_rd_addr  out  ADDR_W  weight buffer address
- act_rd_en  out  1  activation buffer read strobe (one word = ACCU_NUM pre-skewed activations)
- act_zero  out  1  forces array activation inputs to 0 (aligned with pe_* signals)
- pe_mac_enable  out  1  to array
- pe_clear_acc  out  1  to array
- pe_weight_partial_sel  out  1  to array; 1 = weight load, 0 = partial-sum compute
- pe_res_shift_num  out  8  to array

Behaviour:
- Reset values:
  - busy, done, wet_rd_en, act_rd_en, act_zero, pe_mac_enable, pe_clear_acc = 0
  - pe_weight_partial_sel = 1
  - addresses = 0
  - pe_res_shift_num = 0
  - FSM = IDLE
- SRAM read latency is 1 cycle. pe_mac_enable, pe_weight_partial_sel and act_zero are registered copies of the state decode, so they change one cycle after the matching rd_en/addr and line up with read data.
- pe_clear_acc is issued directly, with no delay.
- On start in IDLE, latch all cfg_* inputs. They are ignored until the next IDLE. pe_res_shift_num = latched cfg_shift, held until the next accepted start.
- States:
  - IDLE: busy=0. On start, if cfg_k_tiles==0 go to DONE; else go to CLEAR.
  - CLEAR: 1 cycle, pe_clear_acc=1, tile=0, then LOAD_W.
  - LOAD_W: ACCU_NUM cycles, i=0..ACCU_NUM-1.
    - wet_rd_en=1, wet_rd_addr = wet_base + tile*ACCU_NUM + i.
    - Delayed sel=1, mac_enable=0.
  - COMPUTE: BN_NUM+ACCU_NUM+1 cycles, j=0..BN_NUM+ACCU_NUM.
    - For j<BN_NUM: act_rd_en=1, act_rd_addr = act_base + tile*BN_NUM + j.
    - For j>=BN_NUM: act_zero=1.
    - Delayed sel=0, mac_enable=1.
    - The 1->0 edge of sel restarts the array's internal pass counter.
    - At the end, tile++. If tile == k_tiles, go to DRAIN; else go to LOAD_W.
  - DRAIN: 3 cycles with all strobes 0, covering the accumulate and saturate register stages.
  - DONE: 1 cycle, done=1, busy=0, then IDLE.
- busy=1 in every state except IDLE and DONE.
- Latency from the start-accept edge to the done-high cycle = 1 + K*(2*ACCU_NUM+BN_NUM+1) + 3 + 1 cycles.
  - Defaults with K=2: 1 + 42 + 3 + 1 = 47.
  - K=0: done one cycle after start.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- tile counter is KT_W bits. cfg_k_tiles = 2^KT_W-1 is legal.
- Boundary conditions:
  - start while busy is ignored, with no queueing.
  - start in the same cycle as done is ignored; it is accepted from IDLE on the next cycle.
  - Reset mid-operation aborts immediately to reset values. No done is issued.
  - pe_clear_acc is asserted only in CLEAR. Passes after the first accumulate onto the previous passes.

Test Plan:
- Reset, then start with k_tiles=1, wet_base=0x010, act_base=0x100, shift=4:
  - wet_rd_addr 0x010..0x014 on 5 consecutive cycles.
  - Then act_rd_addr 0x100..0x109 followed by 6 act_zero cycles.
  - pe_res_shift_num=4; done 26 cycles after accept.
- k_tiles=2, wet_base=0, act_base=0x200: second pass reads weights 5..9 and activations 0x20A..0x213. pe_clear_acc pulses exactly once. done at cycle 47.
- k_tiles=0 -> busy never rises; done pulses on the cycle after start; no rd_en or pe_* activity.
- start re-pulsed at cycle 10 with different cfg -> ignored; addresses still follow the original cfg; exactly one done.
- reset_n low during COMPUTE of tile 0 -> all outputs return to reset values asynchronously; no done. A new start after release behaves as the first scenario.
- wet_base=0xFFE, k_tiles=1 -> wet_rd_addr sequence 0xFFE, 0xFFF, 0x000, 0x001, 0x002.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
// Tile sequencer for a 1xN systolic MAC array: clear, K passes of weight load
// and activation compute, then drain. Issues buffer reads and aligned array control.
module systolic_array_ctrl #(
  parameter int BN_NUM   = 10,
  parameter int ACCU_NUM = 5,
  parameter int ADDR_W   = 12,
  parameter int KT_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [KT_W-1:0]   cfg_k_tiles,
  input  logic [7:0]        cfg_shift,
  input  logic [ADDR_W-1:0] cfg_wet_base,
  input  logic [ADDR_W-1:0] cfg_act_base,
  output logic              busy,
  output logic              done,
  output logic              wet_rd_en,
  output logic [ADDR_W-1:0] wet_rd_addr,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              act_zero,
  output logic              pe_mac_enable,
  output logic              pe_clear_acc,
  output logic              pe_weight_partial_sel,
  output logic [7:0]        pe_res_shift_num,
  output logic [2:0]        dbg_state
);

  // Handshake: start is a one-cycle command sampled only while idle (busy=0 and
  // done=0); the block answers with a single-cycle done pulse, after which it is
  // idle again and accepts the next start one cycle later.

  localparam int CMP_CYCLES = BN_NUM + ACCU_NUM + 1;
  localparam int CNT_W      = $clog2(CMP_CYCLES + 1);

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(ACCU_NUM - 1);
  localparam logic [CNT_W-1:0] CMP_LAST   = CNT_W'(CMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(BN_NUM - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD_W  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [KT_W-1:0]   tile_q;
  logic [KT_W-1:0]   k_q;
  logic [7:0]        shift_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] aptr_q;

  logic              busy_q;
  logic              done_q;
  logic              clear_q;
  logic              wet_en_q;
  logic [ADDR_W-1:0] wet_addr_q;
  logic              act_en_q;
  logic [ADDR_W-1:0] act_addr_q;

  // Stage-1 decode travels with the read strobe; stage 2 lines up with read data.
  logic              mac_s1_q;
  logic              sel_s1_q;
  logic              zero_s1_q;
  logic              mac_q;
  logic              sel_q;
  logic              zero_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tile_q     <= '0;
      k_q        <= '0;
      shift_q    <= '0;
      wptr_q     <= '0;
      aptr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clear_q    <= 1'b0;
      wet_en_q   <= 1'b0;
      wet_addr_q <= '0;
      act_en_q   <= 1'b0;
      act_addr_q <= '0;
      mac_s1_q   <= 1'b0;
      sel_s1_q   <= 1'b1;
      zero_s1_q  <= 1'b0;
      mac_q      <= 1'b0;
      sel_q      <= 1'b1;
      zero_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      clear_q   <= 1'b0;
      wet_en_q  <= 1'b0;
      act_en_q  <= 1'b0;
      mac_s1_q  <= 1'b0;
      sel_s1_q  <= 1'b1;
      zero_s1_q <= 1'b0;
      mac_q     <= mac_s1_q;
      sel_q     <= sel_s1_q;
      zero_q    <= zero_s1_q;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            k_q     <= cfg_k_tiles;
            shift_q <= cfg_shift;
            wptr_q  <= cfg_wet_base;
            aptr_q  <= cfg_act_base;
            if (cfg_k_tiles == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CLEAR;
              clear_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          state_q    <= S_LOAD_W;
          cnt_q      <= '0;
          tile_q     <= '0;
          wet_en_q   <= 1'b1;
          wet_addr_q <= wptr_q;
          wptr_q     <= wptr_q + ADDR_W'(1);
        end

        S_LOAD_W: begin
          if (cnt_q == LOAD_LAST) begin
            state_q    <= S_COMPUTE;
            cnt_q      <= '0;
            act_en_q   <= 1'b1;
            act_addr_q <= aptr_q;
            aptr_q     <= aptr_q + ADDR_W'(1);
            mac_s1_q   <= 1'b1;
            sel_s1_q   <= 1'b0;
          end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            wet_en_q   <= 1'b1;
            wet_addr_q <= wptr_q;
            wptr_q     <= wptr_q + ADDR_W'(1);
          end
        end

        S_COMPUTE: begin
          if (cnt_q == CMP_LAST) begin
            tile_q <= tile_q + KT_W'(1);
            cnt_q  <= '0;
            if (tile_q + KT_W'(1) == k_q) begin
              state_q <= S_DRAIN;
            end else begin
              state_q    <= S_LOAD_W;
              wet_en_q   <= 1'b1;
              wet_addr_q <= wptr_q;
              wptr_q     <= wptr_q + ADDR_W'(1);
            end
          end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
            mac_s1_q <= 1'b1;
            sel_s1_q <= 1'b0;
            // Past the last activation word the tail cycles flush the skew with zeros.
            if (cnt_q < ACT_LAST) begin
              act_en_q   <= 1'b1;
              act_addr_q <= aptr_q;
              aptr_q     <= aptr_q + ADDR_W'(1);
            end else begin
              zero_s1_q <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign wet_rd_en             = wet_en_q;
  assign wet_rd_addr           = wet_addr_q;
  assign act_rd_en             = act_en_q;
  assign act_rd_addr           = act_addr_q;
  assign act_zero              = zero_q;
  assign pe_mac_enable         = mac_q;
  assign pe_clear_acc          = clear_q;
  assign pe_weight_partial_sel = sel_q;
  assign pe_res_shift_num      = shift_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: cycle-by-cycle comparison against a
// formula-based schedule model derived from pass lengths and buffer layout.
module tb_systolic_array_ctrl;

  localparam int A  = 5;
  localparam int B  = 10;
  localparam int AW = 12;
  localparam int KW = 8;
  localparam int P  = 2 * A + B + 1;

  localparam logic [39:0] RESET_VEC = 40'h00_0000_0100;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [KW-1:0] cfg_k_tiles;
  logic [7:0]    cfg_shift;
  logic [AW-1:0] cfg_wet_base;
  logic [AW-1:0] cfg_act_base;
  logic          busy;
  logic          done;
  logic          wet_rd_en;
  logic [AW-1:0] wet_rd_addr;
  logic          act_rd_en;
  logic [AW-1:0] act_rd_addr;
  logic          act_zero;
  logic          pe_mac_enable;
  logic          pe_clear_acc;
  logic          pe_weight_partial_sel;
  logic [7:0]    pe_res_shift_num;
  logic [2:0]    dbg_state;

  int tests_run;
  int tests_failed;

  systolic_array_ctrl dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .start                 (start),
    .cfg_k_tiles           (cfg_k_tiles),
    .cfg_shift             (cfg_shift),
    .cfg_wet_base          (cfg_wet_base),
    .cfg_act_base          (cfg_act_base),
    .busy                  (busy),
    .done                  (done),
    .wet_rd_en             (wet_rd_en),
    .wet_rd_addr           (wet_rd_addr),
    .act_rd_en             (act_rd_en),
    .act_rd_addr           (act_rd_addr),
    .act_zero              (act_zero),
    .pe_mac_enable         (pe_mac_enable),
    .pe_clear_acc          (pe_clear_acc),
    .pe_weight_partial_sel (pe_weight_partial_sel),
    .pe_res_shift_num      (pe_res_shift_num),
    .dbg_state             (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index of the done pulse, counted from the accept edge.
  function automatic int tlen(int k);
    return (k == 0) ? 1 : (1 + k * P + 3 + 1);
  endfunction

  // Reference schedule: cycle t after accept -> expected packed outputs.
  function automatic logic [39:0] exp_at(int t, int k, int wb, int ab, int sh);
    int last, u, tl, r;
    logic bsy, dn, we, ae, z, m, c, s;
    logic [AW-1:0] wa, aa;
    last = 2 + k * P;
    bsy = (k > 0) && (t < tlen(k));
    dn  = (t == tlen(k));
    c   = (k > 0) && (t == 1);
    we = 1'b0; ae = 1'b0; z = 1'b0; m = 1'b0; s = 1'b1;
    wa = '0; aa = '0;
    if (t >= 2 && t < last) begin
      u = t - 2; tl = u / P; r = u % P;
      if (r < A) begin
        we = 1'b1; wa = AW'(wb + tl * A + r);
      end else if (r - A < B) begin
        ae = 1'b1; aa = AW'(ab + tl * B + r - A);
      end
    end
    if (t - 1 >= 2 && t - 1 < last) begin
      r = (t - 3) % P;
      if (r >= A) begin
        s = 1'b0; m = 1'b1; z = ((r - A) >= B);
      end
    end
    return {bsy, dn, we, wa, ae, aa, z, m, c, s, 8'(sh)};
  endfunction

  function automatic logic [39:0] obs_vec();
    return {busy, done, wet_rd_en, (wet_rd_en ? wet_rd_addr : 12'h000),
            act_rd_en, (act_rd_en ? act_rd_addr : 12'h000),
            act_zero, pe_mac_enable, pe_clear_acc, pe_weight_partial_sel,
            pe_res_shift_num};
  endfunction

  // driver: issue a start; returns at the negedge of cycle 1 after accept
  task automatic drive_start(input int k, input int wb, input int ab, input int sh);
    @(negedge clk);
    cfg_k_tiles  = KW'(k);
    cfg_wet_base = AW'(wb);
    cfg_act_base = AW'(ab);
    cfg_shift    = 8'(sh);
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [39:0] o;
    reset_n = 1'b0;
    start = 1'b0; cfg_k_tiles = '0; cfg_shift = '0; cfg_wet_base = '0; cfg_act_base = '0;
    repeat (3) @(negedge clk);
    o = obs_vec();
    tests_run++;
    if (o !== RESET_VEC) begin
      tests_failed++; $display("FAIL reset_vals got=%h exp=%h", o, RESET_VEC);
    end
    tests_run++;
    if (dbg_state !== 3'd0) begin
      tests_failed++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    o = obs_vec();
    tests_run++;
    if (o !== RESET_VEC) begin
      tests_failed++; $display("FAIL idle_after_reset got=%h exp=%h", o, RESET_VEC);
    end
  endtask

  task automatic test_single_tile(input string nm, input int k, input int wb, input int ab, input int sh);
    logic [39:0] o, e;
    int tl;
    tl = tlen(k);
    drive_start(k, wb, ab, sh);
    for (int t = 1; t <= tl + 2; t++) begin
      o = obs_vec(); e = exp_at(t, k, wb, ab, sh);
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL %s t=%0d got=%h exp=%h", nm, t, o, e);
      end
      if (t < tl + 2) @(negedge clk);
    end
  endtask

  task automatic test_two_tiles();
    logic [39:0] o, e;
    int tl, clears, sh;
    sh = int'($urandom_range(0, 255));
    tl = tlen(2);
    clears = 0;
    drive_start(2, 0, 'h200, sh);
    for (int t = 1; t <= tl + 2; t++) begin
      o = obs_vec(); e = exp_at(t, 2, 0, 'h200, sh);
      if (pe_clear_acc) clears++;
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL two_tiles t=%0d got=%h exp=%h", t, o, e);
      end
      if (t < tl + 2) @(negedge clk);
    end
    tests_run++;
    if (clears != 1) begin
      tests_failed++; $display("FAIL clear_count got=%0d exp=1", clears);
    end
  endtask

  task automatic test_restart_ignored();
    logic [39:0] o, e;
    int tl, dones;
    tl = tlen(1);
    dones = 0;
    drive_start(1, 'h040, 'h300, 7);
    for (int t = 1; t <= tl + 2; t++) begin
      o = obs_vec(); e = exp_at(t, 1, 'h040, 'h300, 7);
      if (done) dones++;
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL restart t=%0d got=%h exp=%h", t, o, e);
      end
      // re-pulse mid-run and again in the done cycle, with a different config
      if (t == 10 || t == tl) begin
        cfg_k_tiles = 8'd3; cfg_wet_base = 12'h777; cfg_act_base = 12'h555;
        cfg_shift = 8'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (t < tl + 2) @(negedge clk);
    end
    tests_run++;
    if (dones != 1) begin
      tests_failed++; $display("FAIL restart_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_reset_mid();
    logic [39:0] o, e;
    int dones;
    dones = 0;
    drive_start(2, 'h020, 'h180, 3);
    for (int t = 1; t <= 12; t++) begin
      o = obs_vec(); e = exp_at(t, 2, 'h020, 'h180, 3);
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL pre_abort t=%0d got=%h exp=%h", t, o, e);
      end
      if (t < 12) @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1 o = obs_vec();
    tests_run++;
    if (o !== RESET_VEC) begin
      tests_failed++; $display("FAIL async_abort got=%h exp=%h", o, RESET_VEC);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    tests_run++;
    if (dones != 0 || dbg_state !== 3'd0) begin
      tests_failed++; $display("FAIL abort_no_done got=%0d/%0d exp=0/0", dones, dbg_state);
    end
  endtask

  task automatic test_random();
    logic [39:0] o, e;
    int k, wb, ab, sh, tl;
    for (int it = 0; it < 8; it++) begin
      k  = int'($urandom_range(0, 3));
      wb = int'($urandom_range(0, 4095));
      ab = int'($urandom_range(0, 4095));
      sh = int'($urandom_range(0, 255));
      tl = tlen(k);
      drive_start(k, wb, ab, sh);
      for (int t = 1; t <= tl + 2; t++) begin
        o = obs_vec(); e = exp_at(t, k, wb, ab, sh);
        tests_run++;
        if (o !== e) begin
          tests_failed++; $display("FAIL random it=%0d k=%0d t=%0d got=%h exp=%h", it, k, t, o, e);
        end
        if (t < tl + 2) @(negedge clk);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single_tile("single", 1, 'h010, 'h100, 4);
    test_two_tiles();
    test_single_tile("zero_tiles", 0, 'h123, 'h456, 11);
    test_restart_ignored();
    test_reset_mid();
    test_single_tile("after_abort", 1, 'h010, 'h100, 4);
    test_single_tile("wet_wrap", 1, 'hFFE, 'h100, 2);
    test_single_tile("act_wrap", 2, 'h000, 'hFFA, 5);
    test_random();
    test_single_tile("max_tiles", 255, 'hF00, 'hA00, 1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
